// File: rtl/bus_terminal_port_if.sv
// Handshake bundle between a bus terminal port and its host/bus neighbours.
// The slave modport is the terminal itself; master is whoever drives it.
interface bus_terminal_port_if #(
  parameter int pckg_sz = 16
);
  logic               host_wr;
  logic [pckg_sz-1:0] host_wdata;
  logic               host_tx_full;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               host_rd;
  logic [pckg_sz-1:0] host_rdata;
  logic               host_rx_valid;
  logic [15:0]        rx_drop_cnt;
  logic [15:0]        rx_ovf_cnt;
  logic [15:0]        tx_ovf_cnt;

  modport slave (
    input  host_wr, host_wdata, pop, push, D_push, host_rd,
    output host_tx_full, pndng, D_pop, host_rdata, host_rx_valid,
           rx_drop_cnt, rx_ovf_cnt, tx_ovf_cnt
  );

  modport master (
    output host_wr, host_wdata, pop, push, D_push, host_rd,
    input  host_tx_full, pndng, D_pop, host_rdata, host_rx_valid,
           rx_drop_cnt, rx_ovf_cnt, tx_ovf_cnt
  );
endinterface

// File: rtl/bus_terminal_port.sv
// Device-side bus terminal: a TX FIFO feeding the bus through pndng/pop/D_pop
// and an address-filtered RX FIFO fed by push/D_push. Both FIFOs are
// first-word-fall-through and show zero when empty.
module bus_terminal_port #(
  parameter int         pckg_sz   = 16,
  parameter int         fifo_size = 15,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  bus_terminal_port_if.slave  bus
);

  localparam int PW = (fifo_size > 1) ? $clog2(fifo_size) : 1;
  localparam int CW = $clog2(fifo_size + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(fifo_size - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(fifo_size);

  // Storage is deliberately left out of reset; occupancy alone defines validity.
  logic [pckg_sz-1:0] tx_mem_q [fifo_size];
  logic [pckg_sz-1:0] rx_mem_q [fifo_size];

  logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [15:0]   tx_ovf_cnt_q, tx_ovf_cnt_d;
  logic [15:0]   rx_ovf_cnt_q, rx_ovf_cnt_d;
  logic [15:0]   rx_drop_cnt_q, rx_drop_cnt_d;

  logic       tx_full, tx_empty, tx_push, tx_pop;
  logic       rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0] rx_dest;
  logic       rx_match;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Handshake qualification and next-state for both FIFOs and the event counters.
  always_comb begin
    tx_full  = (tx_cnt_q == CNT_FULL);
    tx_empty = (tx_cnt_q == '0);
    rx_full  = (rx_cnt_q == CNT_FULL);
    rx_empty = (rx_cnt_q == '0);

    // A pop frees a slot in the same edge, so a write to a full FIFO still lands.
    tx_pop  = bus.pop && !tx_empty;
    tx_push = bus.host_wr && (!tx_full || tx_pop);

    rx_dest  = bus.D_push[pckg_sz-1 -: 8];
    rx_match = bus.push && ((rx_dest == id) || (rx_dest == broadcast));
    rx_pop   = bus.host_rd && !rx_empty;
    rx_push  = rx_match && (!rx_full || rx_pop);

    tx_wr_ptr_d = tx_push ? ptr_inc(tx_wr_ptr_q) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? ptr_inc(tx_rd_ptr_q) : tx_rd_ptr_q;
    rx_wr_ptr_d = rx_push ? ptr_inc(rx_wr_ptr_q) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? ptr_inc(rx_rd_ptr_q) : rx_rd_ptr_q;

    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase

    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase

    tx_ovf_cnt_d  = (bus.host_wr && !tx_push) ? sat_inc(tx_ovf_cnt_q) : tx_ovf_cnt_q;
    rx_ovf_cnt_d  = (rx_match && !rx_push)    ? sat_inc(rx_ovf_cnt_q) : rx_ovf_cnt_q;
    rx_drop_cnt_d = (bus.push && !rx_match)   ? sat_inc(rx_drop_cnt_q) : rx_drop_cnt_q;
  end

  // Pointer, occupancy and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      tx_cnt_q      <= '0;
      rx_cnt_q      <= '0;
      tx_ovf_cnt_q  <= '0;
      rx_ovf_cnt_q  <= '0;
      rx_drop_cnt_q <= '0;
    end else begin
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_ovf_cnt_q  <= tx_ovf_cnt_d;
      rx_ovf_cnt_q  <= rx_ovf_cnt_d;
      rx_drop_cnt_q <= rx_drop_cnt_d;
    end
  end

  // FIFO storage writes; handshakes in a reset cycle are ignored.
  always_ff @(posedge clk) begin
    if (!reset && tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.host_wdata;
    if (!reset && rx_push) rx_mem_q[rx_wr_ptr_q] <= bus.D_push;
  end

  assign bus.pndng         = !tx_empty;
  assign bus.host_tx_full  = tx_full;
  assign bus.D_pop         = tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q];
  assign bus.host_rx_valid = !rx_empty;
  assign bus.host_rdata    = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
  assign bus.tx_ovf_cnt    = tx_ovf_cnt_q;
  assign bus.rx_ovf_cnt    = rx_ovf_cnt_q;
  assign bus.rx_drop_cnt   = rx_drop_cnt_q;

endmodule

// File: tb/tb_bus_terminal_port.sv
// Bench for bus_terminal_port (id = 8'h03): directed scenarios plus a random
// run against a queue-based reference model of the terminal.
module tb_bus_terminal_port;
  localparam int         PW    = 16;
  localparam int         DEPTH = 15;
  localparam logic [7:0] MYID  = 8'h03;
  localparam logic [7:0] BC    = 8'hFF;

  logic clk;
  logic reset;
  bus_terminal_port_if #(.pckg_sz(PW)) bif ();

  bus_terminal_port #(.pckg_sz(PW), .fifo_size(DEPTH), .id(MYID), .broadcast(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [PW-1:0] tx_q[$];
  logic [PW-1:0] rx_q[$];
  int m_tx_ovf, m_rx_ovf, m_rx_drop;

  // Model follows the terminal's documented rules on every clock edge.
  task automatic step();
    logic pop_ok, rd_ok;
    logic [7:0] dest;
    @(posedge clk);
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_tx_ovf = 0; m_rx_ovf = 0; m_rx_drop = 0;
    end else begin
      pop_ok = bif.pop && (tx_q.size() > 0);
      if (pop_ok) void'(tx_q.pop_front());
      if (bif.host_wr) begin
        if (tx_q.size() < DEPTH) tx_q.push_back(bif.host_wdata);
        else if (m_tx_ovf < 65535) m_tx_ovf++;
      end
      rd_ok = bif.host_rd && (rx_q.size() > 0);
      if (rd_ok) void'(rx_q.pop_front());
      if (bif.push) begin
        dest = bif.D_push[PW-1:PW-8];
        if (dest == MYID || dest == BC) begin
          if (rx_q.size() < DEPTH) rx_q.push_back(bif.D_push);
          else if (m_rx_ovf < 65535) m_rx_ovf++;
        end else if (m_rx_drop < 65535) m_rx_drop++;
      end
    end
    #1;
    reset = 1'b0;
    bif.host_wr = 1'b0; bif.pop = 1'b0; bif.push = 1'b0; bif.host_rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({bif.pndng, bif.host_tx_full, bif.host_rx_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags got pndng=%0b full=%0b rx_valid=%0b exp 0 0 0",
               bif.pndng, bif.host_tx_full, bif.host_rx_valid);
    end
    tests_run++;
    if ({bif.D_pop, bif.host_rdata} !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data got D_pop=%h host_rdata=%h exp 0000 0000", bif.D_pop, bif.host_rdata);
    end
    tests_run++;
    if ({bif.tx_ovf_cnt, bif.rx_ovf_cnt, bif.rx_drop_cnt} !== 48'h0) begin
      tests_failed++;
      $display("FAIL reset_counters got %0d %0d %0d exp 0 0 0",
               bif.tx_ovf_cnt, bif.rx_ovf_cnt, bif.rx_drop_cnt);
    end
  endtask

  task automatic test_idle_handshakes();
    do_reset();
    bif.pop = 1'b1; bif.host_rd = 1'b1;
    step();
    tests_run++;
    if ({bif.pndng, bif.host_rx_valid, bif.D_pop, bif.host_rdata} !== 34'h0) begin
      tests_failed++;
      $display("FAIL idle_outputs got pndng=%0b rx_valid=%0b D_pop=%h rdata=%h exp all 0",
               bif.pndng, bif.host_rx_valid, bif.D_pop, bif.host_rdata);
    end
    tests_run++;
    if ({bif.tx_ovf_cnt, bif.rx_ovf_cnt, bif.rx_drop_cnt} !== 48'h0) begin
      tests_failed++;
      $display("FAIL idle_counters got %0d %0d %0d exp 0 0 0",
               bif.tx_ovf_cnt, bif.rx_ovf_cnt, bif.rx_drop_cnt);
    end
    bif.host_wr = 1'b1; bif.host_wdata = 16'h1234;
    step();
    tests_run++;
    if ({bif.pndng, bif.D_pop} !== {1'b1, 16'h1234}) begin
      tests_failed++;
      $display("FAIL idle_then_write got pndng=%0b D_pop=%h exp 1 1234", bif.pndng, bif.D_pop);
    end
    bif.pop = 1'b1;
    step();
    tests_run++;
    if ({bif.pndng, bif.D_pop} !== 17'h0) begin
      tests_failed++;
      $display("FAIL idle_drain got pndng=%0b D_pop=%h exp 0 0000", bif.pndng, bif.D_pop);
    end
  endtask

  task automatic test_tx_order();
    logic [PW-1:0] exp_v [3];
    exp_v[0] = 16'h0A01; exp_v[1] = 16'h0A02; exp_v[2] = 16'h0A03;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bif.host_wr = 1'b1; bif.host_wdata = exp_v[i];
      step();
      if (i == 0) begin
        tests_run++;
        if ({bif.pndng, bif.D_pop} !== {1'b1, 16'h0A01}) begin
          tests_failed++;
          $display("FAIL tx_first_latency got pndng=%0b D_pop=%h exp 1 0a01", bif.pndng, bif.D_pop);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bif.D_pop !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL tx_order[%0d] got D_pop=%h exp %h", i, bif.D_pop, exp_v[i]);
      end
      bif.pop = 1'b1;
      step();
    end
    tests_run++;
    if ({bif.pndng, bif.D_pop} !== 17'h0) begin
      tests_failed++;
      $display("FAIL tx_empty_after got pndng=%0b D_pop=%h exp 0 0000", bif.pndng, bif.D_pop);
    end
  endtask

  task automatic test_tx_full();
    logic [PW-1:0] v [16];
    int n;
    do_reset();
    for (int i = 0; i < 16; i++) v[i] = PW'($urandom);
    for (int i = 0; i < DEPTH; i++) begin
      bif.host_wr = 1'b1; bif.host_wdata = v[i];
      step();
    end
    tests_run++;
    if ({bif.host_tx_full, bif.tx_ovf_cnt} !== {1'b1, 16'd0}) begin
      tests_failed++;
      $display("FAIL tx_fill got full=%0b tx_ovf=%0d exp 1 0", bif.host_tx_full, bif.tx_ovf_cnt);
    end
    bif.host_wr = 1'b1; bif.host_wdata = 16'hDEAD;
    step();
    tests_run++;
    if ({bif.host_tx_full, bif.tx_ovf_cnt} !== {1'b1, 16'd1}) begin
      tests_failed++;
      $display("FAIL tx_overflow got full=%0b tx_ovf=%0d exp 1 1", bif.host_tx_full, bif.tx_ovf_cnt);
    end
    v[15] = 16'hBEEF;
    bif.host_wr = 1'b1; bif.host_wdata = v[15]; bif.pop = 1'b1;
    step();
    tests_run++;
    if ({bif.host_tx_full, bif.tx_ovf_cnt, bif.D_pop} !== {1'b1, 16'd1, v[1]}) begin
      tests_failed++;
      $display("FAIL tx_wr_pop_full got full=%0b tx_ovf=%0d D_pop=%h exp 1 1 %h",
               bif.host_tx_full, bif.tx_ovf_cnt, bif.D_pop, v[1]);
    end
    n = 1;
    while (bif.pndng && n < 20) begin
      tests_run++;
      if (bif.D_pop !== v[n]) begin
        tests_failed++;
        $display("FAIL tx_drain[%0d] got D_pop=%h exp %h", n, bif.D_pop, v[n]);
      end
      bif.pop = 1'b1;
      step();
      n++;
    end
    tests_run++;
    if (n !== 16) begin
      tests_failed++;
      $display("FAIL tx_drain_count got %0d entries exp 15", n - 1);
    end
  endtask

  task automatic test_rx_filter();
    do_reset();
    bif.push = 1'b1; bif.D_push = 16'h0355; step();
    bif.push = 1'b1; bif.D_push = 16'hFF77; step();
    bif.push = 1'b1; bif.D_push = 16'h0499; step();
    tests_run++;
    if ({bif.rx_drop_cnt, bif.rx_ovf_cnt} !== {16'd1, 16'd0}) begin
      tests_failed++;
      $display("FAIL rx_drop got drop=%0d ovf=%0d exp 1 0", bif.rx_drop_cnt, bif.rx_ovf_cnt);
    end
    tests_run++;
    if ({bif.host_rx_valid, bif.host_rdata} !== {1'b1, 16'h0355}) begin
      tests_failed++;
      $display("FAIL rx_first got valid=%0b rdata=%h exp 1 0355", bif.host_rx_valid, bif.host_rdata);
    end
    bif.host_rd = 1'b1; step();
    tests_run++;
    if ({bif.host_rx_valid, bif.host_rdata} !== {1'b1, 16'hFF77}) begin
      tests_failed++;
      $display("FAIL rx_broadcast got valid=%0b rdata=%h exp 1 ff77", bif.host_rx_valid, bif.host_rdata);
    end
    bif.host_rd = 1'b1; step();
    tests_run++;
    if ({bif.host_rx_valid, bif.host_rdata} !== 17'h0) begin
      tests_failed++;
      $display("FAIL rx_empty got valid=%0b rdata=%h exp 0 0000", bif.host_rx_valid, bif.host_rdata);
    end
  endtask

  task automatic test_rx_overflow();
    int n;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bif.push = 1'b1; bif.D_push = {MYID, 8'(i)};
      step();
    end
    tests_run++;
    if ({bif.rx_ovf_cnt, bif.host_rdata} !== {16'd2, 16'h0300}) begin
      tests_failed++;
      $display("FAIL rx_overflow got ovf=%0d rdata=%h exp 2 0300", bif.rx_ovf_cnt, bif.host_rdata);
    end
    bif.push = 1'b1; bif.D_push = 16'h03AA; bif.host_rd = 1'b1;
    step();
    tests_run++;
    if ({bif.rx_ovf_cnt, bif.host_rdata} !== {16'd2, 16'h0301}) begin
      tests_failed++;
      $display("FAIL rx_push_rd_full got ovf=%0d rdata=%h exp 2 0301", bif.rx_ovf_cnt, bif.host_rdata);
    end
    n = 0;
    while (bif.host_rx_valid && n < 20) begin
      if (n == 14) begin
        tests_run++;
        if (bif.host_rdata !== 16'h03AA) begin
          tests_failed++;
          $display("FAIL rx_last_entry got rdata=%h exp 03aa", bif.host_rdata);
        end
      end
      bif.host_rd = 1'b1;
      step();
      n++;
    end
    tests_run++;
    if (n !== 15) begin
      tests_failed++;
      $display("FAIL rx_stored_count got %0d exp 15", n);
    end
  endtask

  task automatic test_reset_mid_traffic();
    do_reset();
    bif.push = 1'b1; bif.D_push = 16'h7711;
    step();
    for (int i = 0; i < 5; i++) begin
      bif.host_wr = 1'b1; bif.host_wdata = 16'h5000 + 16'(i);
      if (i < 4) begin bif.push = 1'b1; bif.D_push = {MYID, 8'(i)}; end
      step();
    end
    tests_run++;
    if ({bif.pndng, bif.host_rx_valid, bif.rx_drop_cnt} !== {2'b11, 16'd1}) begin
      tests_failed++;
      $display("FAIL pre_reset_state got pndng=%0b rx_valid=%0b drop=%0d exp 1 1 1",
               bif.pndng, bif.host_rx_valid, bif.rx_drop_cnt);
    end
    reset = 1'b1;
    bif.host_wr = 1'b1; bif.host_wdata = 16'hAAAA; bif.pop = 1'b1;
    bif.push = 1'b1; bif.D_push = 16'h03BB; bif.host_rd = 1'b1;
    step();
    tests_run++;
    if ({bif.pndng, bif.host_rx_valid, bif.D_pop, bif.host_rdata} !== 34'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs got pndng=%0b rx_valid=%0b D_pop=%h rdata=%h exp all 0",
               bif.pndng, bif.host_rx_valid, bif.D_pop, bif.host_rdata);
    end
    tests_run++;
    if ({bif.tx_ovf_cnt, bif.rx_ovf_cnt, bif.rx_drop_cnt} !== 48'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_counters got %0d %0d %0d exp 0 0 0",
               bif.tx_ovf_cnt, bif.rx_ovf_cnt, bif.rx_drop_cnt);
    end
  endtask

  task automatic test_random();
    int wr_pct, rd_pct;
    logic [PW-1:0] e_dpop, e_rdata;
    logic [7:0] dest;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      wr_pct = (cyc < 300) ? 80 : 30;
      rd_pct = (cyc < 300) ? 25 : 75;
      bif.host_wr    = ($urandom_range(99) < wr_pct);
      bif.host_wdata = PW'($urandom);
      bif.pop        = ($urandom_range(99) < rd_pct);
      bif.push       = ($urandom_range(99) < wr_pct);
      case ($urandom_range(2))
        0:       dest = MYID;
        1:       dest = BC;
        default: dest = 8'($urandom);
      endcase
      bif.D_push  = {dest, 8'($urandom)};
      bif.host_rd = ($urandom_range(99) < rd_pct);
      step();
      e_dpop  = (tx_q.size() > 0) ? tx_q[0] : '0;
      e_rdata = (rx_q.size() > 0) ? rx_q[0] : '0;
      tests_run++;
      if ({bif.pndng, bif.host_tx_full, bif.D_pop} !==
          {tx_q.size() != 0, tx_q.size() == DEPTH, e_dpop}) begin
        tests_failed++;
        $display("FAIL rand_tx cyc=%0d got pndng=%0b full=%0b D_pop=%h exp %0b %0b %h", cyc,
                 bif.pndng, bif.host_tx_full, bif.D_pop, tx_q.size() != 0, tx_q.size() == DEPTH, e_dpop);
      end
      tests_run++;
      if ({bif.host_rx_valid, bif.host_rdata} !== {rx_q.size() != 0, e_rdata}) begin
        tests_failed++;
        $display("FAIL rand_rx cyc=%0d got valid=%0b rdata=%h exp %0b %h", cyc,
                 bif.host_rx_valid, bif.host_rdata, rx_q.size() != 0, e_rdata);
      end
      tests_run++;
      if ({bif.tx_ovf_cnt, bif.rx_ovf_cnt, bif.rx_drop_cnt} !==
          {16'(m_tx_ovf), 16'(m_rx_ovf), 16'(m_rx_drop)}) begin
        tests_failed++;
        $display("FAIL rand_cnt cyc=%0d got %0d %0d %0d exp %0d %0d %0d", cyc,
                 bif.tx_ovf_cnt, bif.rx_ovf_cnt, bif.rx_drop_cnt, m_tx_ovf, m_rx_ovf, m_rx_drop);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bif.host_wr = 1'b0; bif.host_wdata = '0; bif.pop = 1'b0;
    bif.push = 1'b0; bif.D_push = '0; bif.host_rd = 1'b0;
    m_tx_ovf = 0; m_rx_ovf = 0; m_rx_drop = 0;
    test_reset();
    test_idle_handshakes();
    test_tx_order();
    test_tx_full();
    test_rx_filter();
    test_rx_overflow();
    test_reset_mid_traffic();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
